unidade_controle_multiciclo: RTL and testbench
==============================================

Name: unidade_controle_multiciclo

Overview:
- Multicycle control FSM for the 8-bit nRisc datapath.
- Directly upstream of the register bank: latches each fetched instruction, decodes it, and drives the bank's read selects, write select and write enable (RegLido1, RegLido2, RegEscrito, EscReg).
- Sequences the memory handshakes for instruction fetch and LW/SW.
- Steers the write-data mux between the ALU result and memory data.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for InstrPronta/MemPronta before entering ERRO. A value of 0 disables the timeout.
- W_CNT, 16, width of the retired-instruction counter (optional feature only).

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Instr  in  8  instruction word from instruction memory
- InstrPronta  in  1  instruction memory ready; Instr is valid this cycle
- MemPronta  in  1  data memory ready; read data valid or write accepted
- ReqInstr  out  1  instruction fetch request
- PCInc  out  1  one-cycle pulse: advance the PC
- MemReq  out  1  data memory request
- MemEsc  out  1  data memory write (valid only with MemReq)
- RegLido1  out  3  register bank read select 1 = IR[5:3] (rs)
- RegLido2  out  3  register bank read select 2 = IR[2:0] (rt)
- RegEscrito  out  3  register bank write select = IR[5:3]
- EscReg  out  1  register bank write enable
- SelDado  out  1  write-data source: 0 = ALU, 1 = memory
- OpULA  out  2  ALU operation: 00 ADD, 01 SUB
- Erro  out  1  sticky handshake-timeout flag

Behaviour:
- Instruction format: op = Instr[7:6], rs = Instr[5:3], rt = Instr[2:0].
  - 00 ADD: rs <= rs + rt
  - 01 SUB: rs <= rs - rt
  - 10 LW: rs <= MEM[rt]
  - 11 SW: MEM[rt] <= rs
- Reset (asynchronous, active-high, takes effect immediately):
  - State = BUSCA, IR = 8'h00, wait counter = 0.
  - Every output is 0, including Erro.
  - A reset asserted during WB cancels the write: EscReg falls with Reset and the bank sees no write edge.
- RegLido1, RegLido2 and RegEscrito are driven from the IR register only, so they change only when IR loads.
- States and transitions:
  - BUSCA: ReqInstr = 1. On InstrPronta: IR <= Instr, PCInc = 1 for that cycle, go to DECOD. Otherwise increment the wait counter.
  - DECOD: one cycle; bank reads settle. Go to EXEC.
  - EXEC: OpULA = 01 if op = SUB, else 00. ADD/SUB go to WB; LW/SW go to MEM.
  - MEM: MemReq = 1; MemEsc = 1 for SW. On MemPronta: LW goes to WB with SelDado = 1, SW goes to BUSCA. Otherwise increment the wait counter.
  - WB: EscReg = 1 for exactly one cycle. SelDado = 1 if LW, else 0. Go to BUSCA.
  - ERRO: all outputs 0 except Erro = 1. Terminal until Reset.
- Wait counter:
  - Cleared on every state entry.
  - In BUSCA or MEM, when MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT without ready: go to ERRO, Erro = 1.
  - A ready arriving in the same cycle the counter reaches MEM_TIMEOUT wins: normal transition, no error.
- Outputs are Moore, decoded from the state register and IR. PCInc is the only output that depends on an input (InstrPronta in BUSCA).
- Latency with ready in the first request cycle: ADD/SUB 4 cycles, LW 5, SW 4 (BUSCA to next BUSCA).
- Instr is sampled only in BUSCA with InstrPronta = 1. MemPronta is ignored outside MEM; InstrPronta is ignored outside BUSCA.
- Back-to-back instructions: WB → BUSCA with no idle cycle.

Optional Feature:
- Macro: CONTROLE_CONTADOR_EN.
- When defined:
  - Adds output port NumInstr [W_CNT-1:0].
  - NumInstr counts retired instructions: +1 on leaving WB, or on leaving MEM for SW.
  - Saturates at all-ones (no wrap). Reset clears it to 0. It does not increment in ERRO.
- When undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset mid-WB: ADD (8'b00_001_010) reaches WB, Reset pulses → EscReg drops to 0 asynchronously; after release ReqInstr = 1, Erro = 0, all selects 0.
- ADD 8'b00_011_101 with InstrPronta in the first cycle → PCInc pulse cycle 0; RegLido1 = 3, RegLido2 = 5 from cycle 1; OpULA = 00 in EXEC; EscReg = 1, RegEscrito = 3, SelDado = 0 in cycle 3; ReqInstr = 1 in cycle 4.
- SUB 8'b01_111_000 → OpULA = 01 only in EXEC; EscReg = 1 with RegEscrito = 7 (a0) one cycle later.
- LW 8'b10_010_110 with MemPronta delayed 3 cycles → MemReq = 1 for 4 cycles, MemEsc = 0; then WB with SelDado = 1, RegEscrito = 2; total 8 cycles.
- SW 8'b11_100_001 → MemReq = MemEsc = 1 until MemPronta; EscReg never asserted; then BUSCA.
- Timeout (MEM_TIMEOUT = 15): hold InstrPronta = 0 → ERRO after 15 wait cycles, Erro = 1, ReqInstr = 0; a later InstrPronta is ignored. Repeat with ready on exactly the 15th cycle → no error. With CONTROLE_CONTADOR_EN and W_CNT = 4: 17 ADDs → NumInstr = 15 (saturated).

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the 8-bit nRisc datapath: fetch, decode, execute, memory and write-back sequencing.
// Optional retired-instruction counter (NumInstr) is enabled by defining CONTROLE_CONTADOR_EN.
module unidade_controle_multiciclo #(
    parameter int MEM_TIMEOUT = 15
`ifdef CONTROLE_CONTADOR_EN
   ,parameter int W_CNT = 16
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Instr,
    input  logic       InstrPronta,
    input  logic       MemPronta,
    output logic       ReqInstr,
    output logic       PCInc,
    output logic       MemReq,
    output logic       MemEsc,
    output logic [2:0] RegLido1,
    output logic [2:0] RegLido2,
    output logic [2:0] RegEscrito,
    output logic       EscReg,
    output logic       SelDado,
    output logic [1:0] OpULA,
    output logic       Erro
`ifdef CONTROLE_CONTADOR_EN
   ,output logic [W_CNT-1:0] NumInstr
`endif
);

    typedef enum logic [2:0] {
        BUSCA,
        DECOD,
        EXEC,
        MEM,
        WB,
        ERRO
    } estadoT;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LW  = 2'b10;
    localparam logic [1:0] OP_SW  = 2'b11;

    // The counter only ever needs to hold 0 .. MEM_TIMEOUT-1; reaching the limit ends the wait.
    localparam int            CW         = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LIMIT      = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam bit            TIMEOUT_ON = (MEM_TIMEOUT != 0);

    estadoT        estado;
    logic [7:0]    ir;
    logic [CW-1:0] waitCnt;
    logic [1:0]    op;
    logic          timeoutHit;

    assign op         = ir[7:6];
    assign timeoutHit = TIMEOUT_ON && (waitCnt == LIMIT);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado  <= BUSCA;
            ir      <= '0;
            waitCnt <= '0;
        end else begin
            case (estado)
                BUSCA: begin
                    if (InstrPronta) begin
                        ir      <= Instr;
                        estado  <= DECOD;
                        waitCnt <= '0;
                    end else if (timeoutHit) begin
                        estado  <= ERRO;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DECOD: estado <= EXEC;
                EXEC:  estado <= op[1] ? MEM : WB;
                MEM: begin
                    // A ready seen on the last allowed cycle still completes normally.
                    if (MemPronta) begin
                        estado  <= (op == OP_LW) ? WB : BUSCA;
                        waitCnt <= '0;
                    end else if (timeoutHit) begin
                        estado  <= ERRO;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                WB:      estado <= BUSCA;
                ERRO:    estado <= ERRO;
                default: estado <= BUSCA;
            endcase
        end
    end

    // Reset gates the two outputs that would otherwise be live in the reset state.
    always_comb begin
        ReqInstr   = (estado == BUSCA) && !Reset;
        PCInc      = (estado == BUSCA) && InstrPronta && !Reset;
        OpULA      = ((estado == EXEC) && (op == OP_SUB)) ? 2'b01 : 2'b00;
        MemReq     = (estado == MEM);
        MemEsc     = (estado == MEM) && (op == OP_SW);
        EscReg     = (estado == WB);
        SelDado    = (estado == WB) && (op == OP_LW);
        Erro       = (estado == ERRO);
        RegLido1   = ir[5:3];
        RegLido2   = ir[2:0];
        RegEscrito = ir[5:3];
    end

`ifdef CONTROLE_CONTADOR_EN
    logic retira;

    assign retira = (estado == WB) || ((estado == MEM) && (op == OP_SW) && MemPronta);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            NumInstr <= '0;
        end else if (retira && (NumInstr != '1)) begin
            NumInstr <= NumInstr + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench: a stimulus driver predicts event timing with plain arithmetic, a monitor pops and compares.
// Builds with or without CONTROLE_CONTADOR_EN, matching the design.
module tb_unidade_controle_multiciclo;

    localparam int MT    = 15;
    localparam int K_PC  = 1;
    localparam int K_SUB = 2;
    localparam int K_MEM = 3;
    localparam int K_WR  = 4;
    localparam int K_ERR = 5;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
        int c;
    } evT;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Instr;
    logic       InstrPronta;
    logic       MemPronta;
    logic       ReqInstr, PCInc, MemReq, MemEsc, EscReg, SelDado, Erro;
    logic [2:0] RegLido1, RegLido2, RegEscrito;
    logic [1:0] OpULA;

`ifdef CONTROLE_CONTADOR_EN
    localparam int WC = 4;
    logic [WC-1:0] NumInstr;
`endif

    evT   q[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;
    bit   monOn   = 1'b0;
    int   expReq  = 0;
    int   expMem  = 0;
    int   seenReq = 0;
    int   seenMem = 0;
    int   retired = 0;
    logic prevErro = 1'b0;

    unidade_controle_multiciclo #(
        .MEM_TIMEOUT(MT)
`ifdef CONTROLE_CONTADOR_EN
       ,.W_CNT(WC)
`endif
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Instr(Instr),
        .InstrPronta(InstrPronta),
        .MemPronta(MemPronta),
        .ReqInstr(ReqInstr),
        .PCInc(PCInc),
        .MemReq(MemReq),
        .MemEsc(MemEsc),
        .RegLido1(RegLido1),
        .RegLido2(RegLido2),
        .RegEscrito(RegEscrito),
        .EscReg(EscReg),
        .SelDado(SelDado),
        .OpULA(OpULA),
        .Erro(Erro)
`ifdef CONTROLE_CONTADOR_EN
       ,.NumInstr(NumInstr)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushEv(input int kind, input int c, input int a, input int b, input int x);
        evT e;
        e.kind = kind;
        e.cyc  = c;
        e.a    = a;
        e.b    = b;
        e.c    = x;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic ip, input logic [7:0] ins, input logic mp);
        InstrPronta = ip;
        Instr       = ins;
        MemPronta   = mp;
        tick();
    endtask

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic errorRecovery();
        for (int k = 0; k < 3; k++) drive(noise(), 8'($urandom), noise());
        Reset       = 1'b1;
        InstrPronta = 1'b0;
        MemPronta   = 1'b0;
        tick();
        Reset   = 1'b0;
        retired = 0;
    endtask

    // d = cycles of InstrPronta delay, m = cycles of MemPronta delay; >= MT means the ready never comes.
    task automatic applyStimulus(input logic [7:0] instr, input int d, input int m);
        int t0;
        int rs;
        int rt;
        logic [1:0] op;
        t0 = cyc;
        op = instr[7:6];
        rs = int'(instr[5:3]);
        rt = int'(instr[2:0]);
        if (d >= MT) begin
            pushEv(K_ERR, t0 + MT, 0, 0, 0);
            for (int k = 0; k < MT; k++) drive(1'b0, 8'($urandom), noise());
            expReq += MT;
            errorRecovery();
            return;
        end
        pushEv(K_PC, t0 + d, 0, 0, 0);
        if (op == 2'b01) pushEv(K_SUB, t0 + d + 2, rs, rt, 0);
        if (!op[1]) pushEv(K_WR, t0 + d + 3, rs, rt, 0);
        else if (m >= MT) pushEv(K_ERR, t0 + d + 3 + MT, 0, 0, 0);
        else begin
            pushEv(K_MEM, t0 + d + 3 + m, rs, rt, (op == 2'b11) ? 1 : 0);
            if (op == 2'b10) pushEv(K_WR, t0 + d + 4 + m, rs, rt, 1);
        end
        for (int k = 0; k <= d; k++) drive(k == d, (k == d) ? instr : 8'($urandom), noise());
        expReq += d + 1;
        drive(noise(), 8'($urandom), noise());
        drive(noise(), 8'($urandom), noise());
        if (!op[1]) begin
            drive(noise(), 8'($urandom), noise());
            retired++;
            return;
        end
        if (m >= MT) begin
            for (int k = 0; k < MT; k++) drive(noise(), 8'($urandom), 1'b0);
            expMem += MT;
            errorRecovery();
            return;
        end
        for (int k = 0; k <= m; k++) drive(noise(), 8'($urandom), k == m);
        expMem += m + 1;
        if (op == 2'b10) drive(noise(), 8'($urandom), noise());
        retired++;
    endtask

    // Monitor: every cycle showing a distinguishing output is matched against the oldest prediction.
    always @(negedge Clock) begin
        int kind;
        evT e;
        if (monOn) begin
            if (!Reset && ReqInstr) seenReq++;
            if (!Reset && MemReq) seenMem++;
            kind = 0;
            if (PCInc) kind = K_PC;
            else if (OpULA != 2'b00) kind = K_SUB;
            else if (MemReq && MemPronta) kind = K_MEM;
            else if (EscReg) kind = K_WR;
            else if (Erro && !prevErro) kind = K_ERR;
            prevErro = Erro;
            if (kind != 0) begin
                if (q.size() == 0) begin
                    checkOutput("unexpectedEvent", kind, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput("evtKind", kind, e.kind);
                    checkOutput("evtCycle", cyc, e.cyc);
                    case (e.kind)
                        K_SUB: begin
                            checkOutput("subOpULA", OpULA, 1);
                            checkOutput("subRegLido1", RegLido1, e.a);
                            checkOutput("subRegLido2", RegLido2, e.b);
                        end
                        K_MEM: begin
                            checkOutput("memMemEsc", MemEsc, e.c);
                            checkOutput("memRegLido1", RegLido1, e.a);
                            checkOutput("memRegLido2", RegLido2, e.b);
                        end
                        K_WR: begin
                            checkOutput("wbRegEscrito", RegEscrito, e.a);
                            checkOutput("wbRegLido2", RegLido2, e.b);
                            checkOutput("wbSelDado", SelDado, e.c);
                        end
                        K_ERR: begin
                            checkOutput("erroReqInstr", ReqInstr, 0);
                            checkOutput("erroMemReq", MemReq, 0);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] dirInstr [8];
        int         dirD     [8];
        int         dirM     [8];
        dirInstr = '{8'b00_011_101, 8'b01_111_000, 8'b10_010_110, 8'b11_100_001,
                     8'b00_000_001, 8'b00_000_001, 8'b10_001_001, 8'b11_001_001};
        dirD     = '{0, 0, 0, 1, 14, 15, 0, 0};
        dirM     = '{0, 0, 3, 2, 0, 0, 14, 15};

        Reset       = 1'b1;
        InstrPronta = 1'b1;
        Instr       = 8'hff;
        MemPronta   = 1'b1;
        tick();
        tick();
        checkOutput("resetOutputs", {ReqInstr, PCInc, MemReq, MemEsc, RegLido1, RegLido2, RegEscrito,
                                     EscReg, SelDado, OpULA, Erro}, 0);

        Reset     = 1'b0;
        MemPronta = 1'b0;
        Instr     = 8'b00_001_010;
        #1;
        checkOutput("releaseReqInstr", ReqInstr, 1);
        checkOutput("fetchPCInc", PCInc, 1);
        tick();
        InstrPronta = 1'b0;
        checkOutput("decodRegLido1", RegLido1, 1);
        checkOutput("decodRegLido2", RegLido2, 2);
        checkOutput("decodPCInc", PCInc, 0);
        tick();
        checkOutput("execOpULA", OpULA, 0);
        tick();
        checkOutput("wbEscReg", EscReg, 1);
        checkOutput("wbRegEscrito", RegEscrito, 1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("resetInWbEscReg", EscReg, 0);
        tick();
        Reset = 1'b0;
        #1;
        checkOutput("postResetReqInstr", ReqInstr, 1);
        checkOutput("postResetErro", Erro, 0);
        checkOutput("postResetSelects", {RegLido1, RegLido2, RegEscrito}, 0);

        monOn = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(dirInstr[i], dirD[i], dirM[i]);
        for (int i = 0; i < 150; i++) begin
            int d;
            int m;
            d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(10, 18)) : int'($urandom_range(0, 2));
            m = ($urandom_range(0, 15) == 0) ? int'($urandom_range(10, 18)) : int'($urandom_range(0, 3));
            applyStimulus(8'($urandom), d, m);
        end
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        expReq += 2;
        monOn = 1'b0;

        checkOutput("pendingEvents", q.size(), 0);
        checkOutput("reqInstrCycles", seenReq, expReq);
        checkOutput("memReqCycles", seenMem, expMem);
`ifdef CONTROLE_CONTADOR_EN
        checkOutput("numInstr", NumInstr, (retired > 15) ? 15 : retired);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
